// File: rtl/rf_2p_fifo_ctrl_pkg.sv
// Shared constants and types for the two-port register-file FIFO controller.
//   RfWordWidth : default data width (matches the RAM word width)
//   RfAddrWidth : default RAM address width
//   OutqDepth   : number of entries in the output queue that hides RAM read latency
package rf_2p_fifo_ctrl_pkg;

  localparam int unsigned RfWordWidth = 32;
  localparam int unsigned RfAddrWidth = 8;
  localparam int unsigned OutqDepth   = 3;

  // Occupancy of the output queue, 0..OutqDepth
  typedef logic [1:0] outq_cnt_t;

endpackage

// File: rtl/rf_2p_fifo_ctrl_if.sv
// Valid/ready push and pop channels of the register-file FIFO.
//   push_valid / push_ready / push_data : producer -> FIFO
//   pop_valid  / pop_ready  / pop_data  : FIFO -> consumer
// Modports: master = producer/consumer side, slave = FIFO controller side.
interface rf_2p_fifo_ctrl_if
  import rf_2p_fifo_ctrl_pkg::*;
#(
  parameter int unsigned Word_Width = RfWordWidth
);

  logic                  push_valid;
  logic                  push_ready;
  logic [Word_Width-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [Word_Width-1:0] pop_data;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );

endinterface

// File: rtl/rf_2p_fifo_ctrl_outq.sv
// Three-entry output queue fed by RAM read data.
// Entry 0 is always the head, so the head is a plain register.
//   clk, rst      : clock, synchronous active-high reset
//   flush_i       : synchronous clear
//   push_i        : write push_data_i at the tail (caller guarantees space)
//   pop_i         : remove the head (ignored when empty)
//   head_o        : registered head entry
//   cnt_o         : number of valid entries
module rf_2p_fifo_ctrl_outq
  import rf_2p_fifo_ctrl_pkg::*;
#(
  parameter int unsigned Word_Width = RfWordWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [Word_Width-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [Word_Width-1:0] head_o,
  output outq_cnt_t             cnt_o
);

  logic [Word_Width-1:0] mem_q [OutqDepth];
  logic [Word_Width-1:0] mem_d [OutqDepth];
  outq_cnt_t             cnt_q, cnt_d, wr_idx;
  logic                  pop_fire;

  assign pop_fire = pop_i & (cnt_q != '0);

  always_comb begin
    mem_d  = mem_q;
    cnt_d  = cnt_q;
    if (pop_fire) begin
      mem_d[0] = mem_q[1];
      mem_d[1] = mem_q[2];
      cnt_d    = cnt_q - outq_cnt_t'(1);
    end
    // Tail slot after any shift from a same-cycle pop
    wr_idx = cnt_q - outq_cnt_t'(pop_fire);
    if (push_i) begin
      mem_d[wr_idx] = push_data_i;
      cnt_d         = cnt_d + outq_cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Data needs no reset: entries are only observed when counted valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_o = mem_q[0];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/rf_2p_fifo_ctrl.sv
// Valid/ready FIFO controller owning an external two-port register file
// (write port B and read port A, both low-active, 1-cycle registered read).
// A 3-entry output queue hides the RAM read latency so 1 word/cycle flows in and out.
// Capacity: 2**Addr_Width words in RAM plus 3 in the queue.
// Optional feature macro RF_FIFO_STATUS_EN adds registered almost_full_o/almost_empty_o.
//   clk, rst        : clock, synchronous active-high reset (rst beats flush_i)
//   flush_i         : synchronous clear of all contents
//   bus (slave)     : push/pop valid-ready channels
//   level_o         : registered word count (RAM + in-flight read + queue)
//   ram_wr_*        : RAM port B (cen/wen low active), driven combinationally on push
//   ram_rd_*        : RAM port A (cen low active); ram_rd_data_i valid the cycle after issue
module rf_2p_fifo_ctrl
  import rf_2p_fifo_ctrl_pkg::*;
#(
  parameter int unsigned Word_Width = RfWordWidth,
  parameter int unsigned Addr_Width = RfAddrWidth
`ifdef RF_FIFO_STATUS_EN
  ,
  parameter int unsigned AF_THRESH  = (1 << Addr_Width) - 4,
  parameter int unsigned AE_THRESH  = 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  rf_2p_fifo_ctrl_if.slave      bus,
  output logic [Addr_Width+1:0] level_o,
  output logic                  ram_wr_cen_o,
  output logic                  ram_wr_wen_o,
  output logic [Addr_Width-1:0] ram_wr_addr_o,
  output logic [Word_Width-1:0] ram_wr_data_o,
  output logic                  ram_rd_cen_o,
  output logic [Addr_Width-1:0] ram_rd_addr_o,
  input  logic [Word_Width-1:0] ram_rd_data_i
`ifdef RF_FIFO_STATUS_EN
  ,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
`endif
);

  localparam int unsigned CntW = Addr_Width + 1;
  localparam int unsigned LvlW = Addr_Width + 2;

  logic [Addr_Width-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       ram_cnt_q, ram_cnt_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  pend_q, push_ready_q;
  outq_cnt_t             q_cnt;
  logic [Word_Width-1:0] q_head;
  logic [2:0]            q_occ;
  logic                  active, push_ready, push_fire, pop_valid, pop_fire, rd_issue;

  assign active     = ~rst & ~flush_i;
  assign push_ready = push_ready_q & active;
  assign push_fire  = bus.push_valid & push_ready;
  assign pop_valid  = (q_cnt != '0) & ~rst;
  assign pop_fire   = pop_valid & bus.pop_ready & ~flush_i;

  // Reserve a queue slot for every read in flight so the queue can never overflow
  assign q_occ    = {1'b0, q_cnt} + {2'b0, pend_q};
  assign rd_issue = active & (ram_cnt_q != '0) & (q_occ < 3'(OutqDepth));

  assign ram_cnt_d = ram_cnt_q + CntW'(push_fire) - CntW'(rd_issue);
  assign level_d   = level_q + LvlW'(push_fire) - LvlW'(pop_fire);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ram_cnt_q    <= '0;
      pend_q       <= 1'b0;
      push_ready_q <= 1'b1;
      level_q      <= '0;
    end else begin
      if (push_fire) wr_ptr_q <= wr_ptr_q + Addr_Width'(1);
      if (rd_issue)  rd_ptr_q <= rd_ptr_q + Addr_Width'(1);
      ram_cnt_q    <= ram_cnt_d;
      pend_q       <= rd_issue;
      // ram_cnt never exceeds DEPTH, so its MSB alone flags "RAM full"
      push_ready_q <= ~ram_cnt_d[CntW-1];
      level_q      <= level_d;
    end
  end

  rf_2p_fifo_ctrl_outq #(
    .Word_Width (Word_Width)
  ) u_outq (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .push_i      (pend_q),
    .push_data_i (ram_rd_data_i),
    .pop_i       (pop_fire),
    .head_o      (q_head),
    .cnt_o       (q_cnt)
  );

  assign bus.push_ready = push_ready;
  assign bus.pop_valid  = pop_valid;
  assign bus.pop_data   = q_head;
  assign level_o        = rst ? '0 : level_q;

  assign ram_wr_cen_o  = ~push_fire;
  assign ram_wr_wen_o  = ~push_fire;
  assign ram_wr_addr_o = wr_ptr_q;
  assign ram_wr_data_o = bus.push_data;
  assign ram_rd_cen_o  = ~rd_issue;
  assign ram_rd_addr_o = rd_ptr_q;

`ifdef RF_FIFO_STATUS_EN
  logic afull_q, aempty_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      afull_q  <= level_q >= LvlW'(AF_THRESH);
      aempty_q <= level_q <= LvlW'(AE_THRESH);
    end
  end

  assign almost_full_o  = afull_q & ~rst;
  assign almost_empty_o = aempty_q | rst;
`endif

endmodule

// File: tb/tb_rf_2p_fifo_ctrl.sv
// Directed bench for rf_2p_fifo_ctrl with a behavioural two-port RAM and a
// queue scoreboard. Define RF_FIFO_STATUS_EN to also exercise the status flags.
module tb_rf_2p_fifo_ctrl;

  localparam int unsigned WW = 32;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  rf_2p_fifo_ctrl_if #(.Word_Width(WW)) bus ();

  logic [AW+1:0] level;
  logic          wr_cen, wr_wen, rd_cen;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [WW-1:0] wr_data, rd_data;
`ifdef RF_FIFO_STATUS_EN
  logic afull, aempty;
`endif

  rf_2p_fifo_ctrl #(
    .Word_Width (WW),
    .Addr_Width (AW)
`ifdef RF_FIFO_STATUS_EN
    ,
    .AF_THRESH  (252),
    .AE_THRESH  (2)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .bus           (bus),
    .level_o       (level),
    .ram_wr_cen_o  (wr_cen),
    .ram_wr_wen_o  (wr_wen),
    .ram_wr_addr_o (wr_addr),
    .ram_wr_data_o (wr_data),
    .ram_rd_cen_o  (rd_cen),
    .ram_rd_addr_o (rd_addr),
    .ram_rd_data_i (rd_data)
`ifdef RF_FIFO_STATUS_EN
    ,
    .almost_full_o  (afull),
    .almost_empty_o (aempty)
`endif
  );

  // Two-port RAM: port B write, port A registered read
  logic [WW-1:0] ram [1 << AW];
  always @(posedge clk) begin
    if (!wr_cen && !wr_wen) ram[wr_addr] <= wr_data;
    if (!rd_cen) rd_data <= ram[rd_addr];
  end

  int total = 0;
  int bad = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [WW-1:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample the current cycle at the falling edge and update the scoreboard
  task automatic smp();
    @(negedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      chk("level", 64'(level), 64'(sb.size()));
      if (!rd_cen && !wr_cen) chk("rd_wr_addr_clash", 64'(rd_addr == wr_addr), 64'd0);
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.pop_valid && bus.pop_ready) begin
          if (sb.size() == 0) chk("pop_unexpected", 64'(bus.pop_valid), 64'd0);
          else begin
            chk("pop_data", 64'(bus.pop_data), 64'(sb.pop_front()));
            n_pop++;
          end
        end
        if (bus.push_valid && bus.push_ready) begin
          sb.push_back(bus.push_data);
          n_push++;
        end
      end
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    smp();
    nxt();
  endtask

  initial begin
    // Reset: a pending push must be ignored
    bus.push_valid = 1'b1;
    bus.push_data  = 32'h1234_5678;
    bus.pop_ready  = 1'b1;
    cyc();
    smp();
    chk("rst_push_ready", 64'(bus.push_ready), 64'd0);
    chk("rst_pop_valid", 64'(bus.pop_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_wr_cen", 64'(wr_cen), 64'd1);
    chk("rst_wr_wen", 64'(wr_wen), 64'd1);
    chk("rst_rd_cen", 64'(rd_cen), 64'd1);
    nxt();
    rst = 1'b0;
    bus.push_valid = 1'b0;
    smp();
    chk("post_rst_push_ready", 64'(bus.push_ready), 64'd1);
    chk("post_rst_pop_valid", 64'(bus.pop_valid), 64'd0);
    nxt();

    // Single word latency
    bus.push_valid = 1'b1;
    bus.push_data  = 32'hA5A5_A5A5;
    smp();
    chk("c0_wr_cen", 64'(wr_cen), 64'd0);
    chk("c0_wr_wen", 64'(wr_wen), 64'd0);
    chk("c0_wr_addr", 64'(wr_addr), 64'd0);
    chk("c0_wr_data", 64'(wr_data), 64'hA5A5_A5A5);
    nxt();
    bus.push_valid = 1'b0;
    smp();
    chk("c1_rd_cen", 64'(rd_cen), 64'd0);
    chk("c1_rd_addr", 64'(rd_addr), 64'd0);
    chk("c1_level", 64'(level), 64'd1);
    nxt();
    smp();
    chk("c2_pop_valid", 64'(bus.pop_valid), 64'd0);
    nxt();
    smp();
    chk("c3_pop_valid", 64'(bus.pop_valid), 64'd1);
    chk("c3_pop_data", 64'(bus.pop_data), 64'hA5A5_A5A5);
    nxt();
    smp();
    chk("c4_level", 64'(level), 64'd0);
    chk("c4_pop_valid", 64'(bus.pop_valid), 64'd0);
    nxt();

    // Streaming: 1000 words, 1 word/cycle after a 3-cycle fill
    n_push = 0;
    n_pop  = 0;
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 1003; i++) begin
      bus.push_valid = (i < 1000);
      bus.push_data  = 32'h1000_0000 + 32'(i);
      cyc();
    end
    bus.push_valid = 1'b0;
    chk("stream_push_cnt", 64'(n_push), 64'd1000);
    chk("stream_pop_cnt", 64'(n_pop), 64'd1000);

    // Fill to capacity with the consumer stalled
    n_push = 0;
    n_pop  = 0;
    bus.pop_ready  = 1'b0;
    bus.push_valid = 1'b1;
    for (int i = 0; i < 270; i++) begin
      bus.push_data = 32'(n_push);
      cyc();
    end
    smp();
    chk("full_push_cnt", 64'(n_push), 64'd259);
    chk("full_push_ready", 64'(bus.push_ready), 64'd0);
    chk("full_level", 64'(level), 64'd259);
    chk("full_pop_valid", 64'(bus.pop_valid), 64'd1);
    chk("full_no_read", 64'(rd_cen), 64'd1);
    nxt();
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b1;
    for (int i = 0; i < 270; i++) cyc();
    chk("drain_pop_cnt", 64'(n_pop), 64'd259);
    chk("drain_pop_valid", 64'(bus.pop_valid), 64'd0);

    // Flush with 10 words held and a read in flight
    bus.pop_ready  = 1'b0;
    bus.push_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      bus.push_data = 32'h100 + 32'(i);
      cyc();
    end
    bus.push_valid = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    bus.pop_ready = 1'b1;
    cyc();
    bus.pop_ready = 1'b0;
    smp();
    chk("pre_flush_rd_issue", 64'(rd_cen), 64'd0);
    nxt();
    flush = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = 32'hDEAD_BEEF;
    smp();
    chk("flush_level_before", 64'(level), 64'd10);
    chk("flush_push_ready", 64'(bus.push_ready), 64'd0);
    chk("flush_wr_cen", 64'(wr_cen), 64'd1);
    chk("flush_rd_cen", 64'(rd_cen), 64'd1);
    nxt();
    flush = 1'b0;
    bus.push_valid = 1'b0;
    smp();
    chk("post_flush_level", 64'(level), 64'd0);
    chk("post_flush_pop_valid", 64'(bus.pop_valid), 64'd0);
    nxt();
    n_pop = 0;
    bus.push_valid = 1'b1;
    bus.push_data  = 32'h0BAD_F00D;
    bus.pop_ready  = 1'b1;
    cyc();
    bus.push_valid = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    chk("post_flush_pop_cnt", 64'(n_pop), 64'd1);

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      bus.push_valid = 1'($urandom_range(0, 1));
      bus.push_data  = $urandom;
      bus.pop_ready  = 1'($urandom_range(0, 1));
      cyc();
    end
    bus.push_valid = 1'b0;
    bus.pop_ready  = 1'b1;
    for (int i = 0; i < 300; i++) cyc();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_pop_valid", 64'(bus.pop_valid), 64'd0);

`ifdef RF_FIFO_STATUS_EN
    bus.pop_ready  = 1'b0;
    bus.push_valid = 1'b1;
    for (int i = 0; i < 252; i++) begin
      bus.push_data = 32'h2000 + 32'(i);
      cyc();
    end
    bus.push_valid = 1'b0;
    smp();
    chk("af_level", 64'(level), 64'd252);
    chk("af_lag", 64'(afull), 64'd0);
    nxt();
    smp();
    chk("af_set", 64'(afull), 64'd1);
    chk("ae_clear", 64'(aempty), 64'd0);
    nxt();
    for (int i = 0; i < 300; i++) begin
      bus.pop_ready = (level > 2);
      cyc();
    end
    bus.pop_ready = 1'b0;
    cyc();
    smp();
    chk("ae_level", 64'(level), 64'd2);
    chk("ae_set", 64'(aempty), 64'd1);
    chk("af_clear", 64'(afull), 64'd0);
    nxt();
    bus.pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
